// File: rtl/mem_test_avm_bridge.sv
// Memory-tester to Avalon-MM master bridge: one outstanding
// transaction, read timeout, saturating counters, sticky errors.
module mem_test_avm_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int WORD_WIDTH     = 64,
  parameter int AVM_ADDR_WIDTH = 27,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     gen_address,
  input  logic [WORD_WIDTH-1:0]     gen_word,
  input  logic                      write,
  input  logic                      read,
  output logic                      confirm,
  output logic [WORD_WIDTH-1:0]     pattern_rb,
  output logic [AVM_ADDR_WIDTH-1:0] avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [WORD_WIDTH-1:0]     avm_writedata,
  output logic [WORD_WIDTH/8-1:0]   avm_byteenable,
  input  logic                      avm_waitrequest,
  input  logic [WORD_WIDTH-1:0]     avm_readdata,
  input  logic                      avm_readdatavalid,
  output logic [31:0]               wr_count,
  output logic [31:0]               rd_count,
  output logic [1:0]                err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_CMD, RD_CMD, RD_WAIT, RECOVER
  } state_e;

  state_e                    state_q, state_d;
  logic [AVM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0]     wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]     pat_q, pat_d;
  logic                      rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic                      confirm_q, confirm_d;
  logic [31:0]               wr_cnt_q, wr_cnt_d;
  logic [31:0]               rd_cnt_q, rd_cnt_d;
  logic [1:0]                err_q, err_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;

  if (ADDR_WIDTH > AVM_ADDR_WIDTH) begin : g_hi
    logic unused_addr_hi;
    assign unused_addr_hi =
      ^gen_address[ADDR_WIDTH-1:AVM_ADDR_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pat_d     = pat_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    confirm_d = 1'b0;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (write) begin
          addr_d  = gen_address[AVM_ADDR_WIDTH-1:0];
          wdata_d = gen_word;
          wr_d    = 1'b1;
          state_d = WR_CMD;
          if (read) err_d[1] = 1'b1;
        end else if (read) begin
          addr_d  = gen_address[AVM_ADDR_WIDTH-1:0];
          rd_d    = 1'b1;
          state_d = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          wr_d      = 1'b0;
          confirm_d = 1'b1;
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
          state_d   = RECOVER;
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          tcnt_d  = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          pat_d     = avm_readdata;
          confirm_d = 1'b1;
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
          state_d   = RECOVER;
        end else if (tcnt_q == T_LAST) begin
          err_d[0]  = 1'b1;
          pat_d     = '1;
          confirm_d = 1'b1;
          state_d   = RECOVER;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      pat_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      confirm_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pat_q     <= pat_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      confirm_q <= confirm_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign confirm        = confirm_q;
  assign pattern_rb     = pat_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;
  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_test_avm_bridge.sv
// Bench for mem_test_avm_bridge: scripted and random transactions
// against a transaction-level model of counts, errors and latency.
module tb_mem_test_avm_bridge;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] gen_address;
  logic [63:0] gen_word;
  logic        write;
  logic        read;
  logic        confirm;
  logic [63:0] pattern_rb;
  logic [26:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] wr_count;
  logic [31:0] rd_count;
  logic [1:0]  err;

  mem_test_avm_bridge #(
    .ADDR_WIDTH(64), .WORD_WIDTH(64),
    .AVM_ADDR_WIDTH(27), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .gen_address(gen_address), .gen_word(gen_word),
    .write(write), .read(read),
    .confirm(confirm), .pattern_rb(pattern_rb),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .wr_count(wr_count), .rd_count(rd_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_wr;
  logic [31:0] exp_rd;
  logic [1:0]  exp_err;
  logic [63:0] exp_pat;

  int          obs_lat;
  int          obs_cmd;
  int          obs_bad;
  bit          obs_both;
  bit          obs_rd_seen;
  bit          obs_conf2;
  logic [63:0] obs_pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_wr  = '0;
    exp_rd  = '0;
    exp_err = '0;
    exp_pat = '0;
  endtask

  // Acts as tester plus Avalon slave for one request; records what it saw.
  task automatic run_txn(input bit wr, input bit rd,
                         input logic [63:0] addr,
                         input logic [63:0] word,
                         input int stall, input int lat,
                         input bit give_valid,
                         input logic [63:0] rdata);
    int stall_left;
    int valid_at;
    write       = wr;
    read        = rd;
    gen_address = addr;
    gen_word    = word;
    tick();
    write       = 1'b0;
    read        = 1'b0;
    gen_address = {$urandom(), $urandom()};
    gen_word    = {$urandom(), $urandom()};
    obs_lat     = -1;
    obs_cmd     = 0;
    obs_bad     = 0;
    obs_both    = 0;
    obs_rd_seen = 0;
    obs_conf2   = 0;
    obs_pat     = '0;
    stall_left  = stall;
    valid_at    = -1;
    for (int i = 1; i <= TO + 200 + stall + lat; i++) begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = {$urandom(), $urandom()};
      if (avm_read && avm_write) obs_both = 1;
      if (avm_read) obs_rd_seen = 1;
      if (confirm) begin
        obs_lat = i - 1;
        obs_pat = pattern_rb;
        break;
      end
      if (avm_write || avm_read) begin
        obs_cmd++;
        if (avm_address !== addr[26:0]) obs_bad++;
        if (avm_write && avm_writedata !== word) obs_bad++;
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) valid_at = i + lat;
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
      if (give_valid && i == valid_at) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rdata;
      end
      tick();
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    tick();
    obs_conf2 = confirm;
  endtask

  task automatic test_reset();
    reset_n           = 1'b1;
    write             = 1'b0;
    read              = 1'b0;
    gen_address       = '0;
    gen_word          = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({confirm, avm_read, avm_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000",
               {confirm, avm_read, avm_write});
    end
    checks++;
    if (avm_address !== '0 || avm_writedata !== '0) begin
      failures++;
      $display("FAIL reset_bus: addr %h data %h want 0",
               avm_address, avm_writedata);
    end
    checks++;
    if (pattern_rb !== exp_pat || err !== exp_err) begin
      failures++;
      $display("FAIL reset_pat_err: pat %h err %b want 0",
               pattern_rb, err);
    end
    checks++;
    if (wr_count !== exp_wr || rd_count !== exp_rd) begin
      failures++;
      $display("FAIL reset_counts: wr %0d rd %0d want 0",
               wr_count, rd_count);
    end
    checks++;
    if (avm_byteenable !== 8'hFF) begin
      failures++;
      $display("FAIL byteenable: got %h want ff", avm_byteenable);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_nostall();
    logic [63:0] w = 64'hA5A5_A5A5_A5A5_A5A5;
    run_txn(1, 0, 64'h400, w, 0, 0, 0, '0);
    exp_wr++;
    checks++;
    if (obs_cmd !== 1 || obs_bad !== 0) begin
      failures++;
      $display("FAIL wr_cmd: cycles %0d bad %0d want 1/0",
               obs_cmd, obs_bad);
    end
    checks++;
    if (obs_lat !== 1) begin
      failures++;
      $display("FAIL wr_latency: got %0d want 1", obs_lat);
    end
    checks++;
    if (wr_count !== exp_wr || obs_conf2 !== 1'b0) begin
      failures++;
      $display("FAIL wr_done: wr %0d conf2 %b want %0d/0",
               wr_count, obs_conf2, exp_wr);
    end
  endtask

  task automatic test_write_stall();
    logic [63:0] w = {$urandom(), $urandom()};
    logic [63:0] a = {$urandom(), $urandom()};
    run_txn(1, 0, a, w, 5, 0, 0, '0);
    exp_wr++;
    checks++;
    if (obs_cmd !== 6 || obs_bad !== 0) begin
      failures++;
      $display("FAIL wr_stall_hold: cycles %0d bad %0d want 6/0",
               obs_cmd, obs_bad);
    end
    checks++;
    if (obs_lat !== 6 || obs_conf2 !== 1'b0) begin
      failures++;
      $display("FAIL wr_stall_confirm: lat %0d conf2 %b want 6/0",
               obs_lat, obs_conf2);
    end
    checks++;
    if (wr_count !== exp_wr) begin
      failures++;
      $display("FAIL wr_stall_count: got %0d want %0d",
               wr_count, exp_wr);
    end
  endtask

  task automatic test_read_latency();
    logic [63:0] r = 64'h5A5A_5A5A_5A5A_5A5A;
    run_txn(0, 1, 64'h1234_5678, '0, 2, 7, 1, r);
    exp_rd++;
    exp_pat = r;
    checks++;
    if (obs_lat !== 2 + 1 + 7) begin
      failures++;
      $display("FAIL rd_latency: got %0d want %0d", obs_lat, 10);
    end
    checks++;
    if (obs_pat !== exp_pat) begin
      failures++;
      $display("FAIL rd_pattern: got %h want %h", obs_pat, exp_pat);
    end
    checks++;
    if (rd_count !== exp_rd || err !== exp_err) begin
      failures++;
      $display("FAIL rd_status: rd %0d err %b want %0d/%b",
               rd_count, err, exp_rd, exp_err);
    end
    checks++;
    if (obs_cmd !== 3 || obs_bad !== 0 || obs_both) begin
      failures++;
      $display("FAIL rd_cmd: cycles %0d bad %0d both %b",
               obs_cmd, obs_bad, obs_both);
    end
  endtask

  task automatic test_stray_valid();
    int conf_seen = 0;
    for (int i = 0; i < 4; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = {$urandom(), $urandom()};
      tick();
      if (confirm) conf_seen++;
    end
    avm_readdatavalid = 1'b0;
    tick();
    if (confirm) conf_seen++;
    checks++;
    if (conf_seen !== 0 || pattern_rb !== exp_pat ||
        rd_count !== exp_rd) begin
      failures++;
      $display("FAIL stray_valid: conf %0d pat %h rd %0d want 0/%h/%0d",
               conf_seen, pattern_rb, rd_count, exp_pat, exp_rd);
    end
  endtask

  task automatic test_timeout();
    run_txn(0, 1, {$urandom(), $urandom()}, '0, 1, 0, 0, '0);
    exp_err[0] = 1'b1;
    exp_pat    = '1;
    checks++;
    if (obs_lat !== 1 + 1 + TO) begin
      failures++;
      $display("FAIL to_latency: got %0d want %0d", obs_lat, TO + 2);
    end
    checks++;
    if (obs_pat !== exp_pat || err !== exp_err) begin
      failures++;
      $display("FAIL to_status: pat %h err %b want %h/%b",
               obs_pat, err, exp_pat, exp_err);
    end
    checks++;
    if (obs_conf2 !== 1'b0 || rd_count !== exp_rd) begin
      failures++;
      $display("FAIL to_pulse: conf2 %b rd %0d want 0/%0d",
               obs_conf2, rd_count, exp_rd);
    end
  endtask

  task automatic test_read_after_timeout();
    logic [63:0] r = {$urandom(), $urandom()};
    run_txn(0, 1, {$urandom(), $urandom()}, '0, 0, 3, 1, r);
    exp_rd++;
    exp_pat = r;
    checks++;
    if (obs_lat !== 4 || obs_pat !== exp_pat || rd_count !== exp_rd) begin
      failures++;
      $display("FAIL rd_after_to: lat %0d pat %h rd %0d want 4/%h/%0d",
               obs_lat, obs_pat, rd_count, exp_pat, exp_rd);
    end
  endtask

  task automatic test_rw_conflict();
    logic [63:0] w = {$urandom(), $urandom()};
    logic [63:0] a = {$urandom(), $urandom()};
    run_txn(1, 1, a, w, 1, 4, 1, {$urandom(), $urandom()});
    exp_wr++;
    exp_err[1] = 1'b1;
    checks++;
    if (obs_rd_seen || obs_cmd !== 2 || obs_bad !== 0) begin
      failures++;
      $display("FAIL rw_conflict_cmd: rd %b cycles %0d bad %0d",
               obs_rd_seen, obs_cmd, obs_bad);
    end
    checks++;
    if (err !== exp_err || wr_count !== exp_wr ||
        rd_count !== exp_rd || pattern_rb !== exp_pat) begin
      failures++;
      $display("FAIL rw_conflict_status: err %b wr %0d rd %0d pat %h",
               err, wr_count, rd_count, pattern_rb);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 40; n++) begin
      int kind  = $urandom_range(0, 2);
      int stall = $urandom_range(0, 3);
      int lat   = $urandom_range(1, 6);
      logic [63:0] a = {$urandom(), $urandom()};
      logic [63:0] w = {$urandom(), $urandom()};
      logic [63:0] r = {$urandom(), $urandom()};
      int want_lat;
      run_txn(kind != 1, kind != 0, a, w, stall, lat, 1, r);
      if (kind == 1) begin
        exp_rd++;
        exp_pat  = r;
        want_lat = stall + 1 + lat;
      end else begin
        exp_wr++;
        if (kind == 2) exp_err[1] = 1'b1;
        want_lat = stall + 1;
      end
      checks++;
      if (obs_lat !== want_lat || obs_cmd !== stall + 1 ||
          obs_bad !== 0 || obs_both || obs_conf2 ||
          (kind != 1 && obs_rd_seen) ||
          obs_pat !== exp_pat || pattern_rb !== exp_pat ||
          wr_count !== exp_wr || rd_count !== exp_rd ||
          err !== exp_err) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d] k%0d: lat %0d/%0d cmd %0d pat %h/%h wr %0d/%0d rd %0d/%0d err %b/%b",
                   n, kind, obs_lat, want_lat, obs_cmd,
                   obs_pat, exp_pat, wr_count, exp_wr,
                   rd_count, exp_rd, err, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int conf_seen = 0;
    read        = 1'b1;
    gen_address = {$urandom(), $urandom()};
    tick();
    read            = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({confirm, avm_read, avm_write} !== 3'b000 ||
        avm_address !== '0 || avm_writedata !== '0) begin
      failures++;
      $display("FAIL midrd_bus: ctl %b addr %h data %h want 0",
               {confirm, avm_read, avm_write},
               avm_address, avm_writedata);
    end
    checks++;
    if (pattern_rb !== exp_pat || wr_count !== exp_wr ||
        rd_count !== exp_rd || err !== exp_err) begin
      failures++;
      $display("FAIL midrd_state: pat %h wr %0d rd %0d err %b want 0",
               pattern_rb, wr_count, rd_count, err);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      avm_readdatavalid = (i < 3);
      avm_readdata      = {$urandom(), $urandom()};
      tick();
      if (confirm) conf_seen++;
    end
    avm_readdatavalid = 1'b0;
    checks++;
    if (conf_seen !== 0 || rd_count !== exp_rd ||
        pattern_rb !== exp_pat) begin
      failures++;
      $display("FAIL midrd_stray: conf %0d rd %0d pat %h want 0/0/0",
               conf_seen, rd_count, pattern_rb);
    end
  endtask

  initial begin
    test_reset();
    test_write_nostall();
    test_write_stall();
    test_read_latency();
    test_stray_valid();
    test_timeout();
    test_read_after_timeout();
    test_rw_conflict();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
